pc_next_unit: RTL

//  Program-counter stage of the mips32 datapath. Holds the PC and fetches each instruction over an imem handshake.

---
 rtl/mips32_pkg.sv | 19 +
 rtl/pc_target_sel.sv | 37 +++
 rtl/pc_next_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 program-counter stage.
package mips32_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } pc_state_t;

    // Instruction addresses are word aligned when the two low bits are clear.
    function automatic logic is_word_aligned(input logic [1:0] addr_low);
        return addr_low == 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register
// targets with fixed priority, plus an alignment flag on the chosen target.
module pc_target_sel
    import mips32_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jr,
    input  logic [PC_WIDTH-1:0] jr_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_imm,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                misaligned
);

    logic [PC_WIDTH-1:0] branch_target;

    always_comb begin
        pc_plus4      = pc + 32'd4;
        // The shift drops branch_imm[31:30]; all sums wrap modulo 2^32.
        branch_target = pc_plus4 + (branch_imm << 2);

        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_addr;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end

        misaligned = !is_word_aligned(next_pc[1:0]);
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: FETCH/EXEC handshake FSM, PC register and retired-instruction counter.
// Define MISALIGN_TRAP_EN to trap misaligned targets to EXC_VECTOR; otherwise the low bits are cleared.
module pc_next_unit
    import mips32_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_imm,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                jr,
    input  logic [PC_WIDTH-1:0] jr_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [3:0]          pc_upper,
    output logic [PC_WIDTH-1:0] instr_count,
    output logic                trap
);

    pc_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] instr_count_q, instr_count_d;
    logic [PC_WIDTH-1:0] next_pc;
    logic                misaligned;

    pc_target_sel u_target_sel (
        .pc           (pc_q),
        .jr           (jr),
        .jr_target    (jr_target),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

`ifndef MISALIGN_TRAP_EN
    logic unused_trap_path;
    assign unused_trap_path = ^{misaligned, next_pc[1:0], EXC_VECTOR};
`endif

    assign pc          = pc_q;
    assign pc_upper    = pc_plus4[31:28];
    assign instr_count = instr_count_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_count_d = instr_count_q;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        trap          = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    instr_count_d = instr_count_q + 32'd1;
                    state_d       = FETCH;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        pc_d = EXC_VECTOR;
                        trap = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
`else
                    pc_d = {next_pc[PC_WIDTH-1:2], 2'b00};
`endif
                end
            end
            default: state_d = FETCH;
        endcase

        // Reset wins over any handshake or commit seen in the same cycle.
        if (reset) begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            trap        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_VECTOR;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule
